// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port arbiter.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  modport slave (
    input  if_req, if_addr, dm_req, dm_addr, dm_we, dm_wdata, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_addr, mem_we, mem_wdata, stall_if, stall_mem
  );
  modport master (
    output if_req, if_addr, dm_req, dm_addr, dm_we, dm_wdata, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_addr, mem_we, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data ports, data first with fetch anti-starvation.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t     state;
  logic [3:0] starve_cnt;
  logic       decide, if_win, dm_win;
  assign decide = (state == IDLE) | bus.mem_ready;
  assign if_win = bus.if_req & (~bus.dm_req | (starve_cnt == LIMIT));
  assign dm_win = bus.dm_req & ~if_win;
  assign bus.if_gnt = rst_n & decide & if_win;
  assign bus.dm_gnt = rst_n & decide & dm_win;
  assign bus.stall_if = rst_n & ((bus.if_req & ~bus.if_gnt) | (state == BUSY_IF & ~bus.mem_ready));
  assign bus.stall_mem = rst_n & ((bus.dm_req & ~bus.dm_gnt) | (state == BUSY_DM & ~bus.mem_ready));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= '0;
      bus.mem_wdata <= '0;
      bus.if_rvalid <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      bus.if_rvalid <= (state == BUSY_IF) & bus.mem_ready;
      bus.dm_rvalid <= (state == BUSY_DM) & bus.mem_ready;
      if (state == BUSY_IF && bus.mem_ready) bus.if_rdata <= bus.mem_rdata;
      // writes complete without touching the load data register
      if (state == BUSY_DM && bus.mem_ready && bus.mem_we == 4'b0000) bus.dm_rdata <= bus.mem_rdata;
      if (decide) begin
        state       <= bus.if_gnt ? BUSY_IF : bus.dm_gnt ? BUSY_DM : IDLE;
        bus.mem_req <= bus.if_gnt | bus.dm_gnt;
      end
      if (bus.if_gnt) begin
        bus.mem_addr  <= bus.if_addr;
        bus.mem_we    <= 4'b0000;
        bus.mem_wdata <= '0;
      end else if (bus.dm_gnt) begin
        bus.mem_addr  <= bus.dm_addr;
        bus.mem_we    <= bus.dm_we;
        bus.mem_wdata <= bus.dm_wdata;
      end
      starve_cnt <= (!bus.if_req || bus.if_gnt) ? 4'd0 :
                    (bus.dm_gnt && starve_cnt != LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic clk, rst_n;
  int   total, bad;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  int          m_owner, m_starve;
  logic [31:0] m_addr, m_wdata, e_if_rd, e_dm_rd;
  logic [3:0]  m_we;
  logic        e_if_rv, e_dm_rv, last_if_gnt, last_dm_gnt;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(logic ir, logic [31:0] ia, logic dr, logic [31:0] da, logic [3:0] dw,
                       logic [31:0] dd, logic rdy, logic [31:0] rd);
    bus.if_req = ir; bus.if_addr = ia; bus.dm_req = dr; bus.dm_addr = da;
    bus.dm_we = dw; bus.dm_wdata = dd; bus.mem_ready = rdy; bus.mem_rdata = rd;
  endtask
  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_addr = 0; m_we = 0; m_wdata = 0;
    e_if_rv = 0; e_dm_rv = 0; e_if_rd = 0; e_dm_rd = 0;
  endtask
  // one clock: check grants/stalls for the driven inputs, advance the model, check registered outputs
  task automatic step();
    logic can, want_if, ei, ed, si, sm;
    #1;
    can = (m_owner == 0) || bus.mem_ready;
    want_if = bus.if_req && (!bus.dm_req || m_starve == LIMIT);
    ei = rst_n && can && want_if;
    ed = rst_n && can && bus.dm_req && !want_if;
    si = rst_n && ((bus.if_req && !ei) || (m_owner == 1 && !bus.mem_ready));
    sm = rst_n && ((bus.dm_req && !ed) || (m_owner == 2 && !bus.mem_ready));
    chk("if_gnt", 32'(bus.if_gnt), 32'(ei));
    chk("dm_gnt", 32'(bus.dm_gnt), 32'(ed));
    chk("stall_if", 32'(bus.stall_if), 32'(si));
    chk("stall_mem", 32'(bus.stall_mem), 32'(sm));
    last_if_gnt = ei;
    last_dm_gnt = ed;
    if (!rst_n) model_reset();
    else begin
      e_if_rv = m_owner == 1 && bus.mem_ready;
      e_dm_rv = m_owner == 2 && bus.mem_ready;
      if (e_if_rv) e_if_rd = bus.mem_rdata;
      if (e_dm_rv && m_we == 0) e_dm_rd = bus.mem_rdata;
      if (ei) begin
        m_owner = 1; m_addr = bus.if_addr; m_we = 0; m_wdata = 0;
      end else if (ed) begin
        m_owner = 2; m_addr = bus.dm_addr; m_we = bus.dm_we; m_wdata = bus.dm_wdata;
      end else if (can) m_owner = 0;
      if (!bus.if_req || ei) m_starve = 0;
      else if (ed && m_starve < LIMIT) m_starve++;
    end
    @(negedge clk);
    chk("mem_req", 32'(bus.mem_req), 32'(m_owner != 0));
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_we", 32'(bus.mem_we), 32'(m_we));
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
    chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(e_dm_rv));
    chk("if_rdata", bus.if_rdata, e_if_rd);
    chk("dm_rdata", bus.dm_rdata, e_dm_rd);
  endtask
  initial begin
    logic [1:0]  exp_seq [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [3:0]  wes [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b1111};
    logic        ir, dr;
    logic [31:0] ia, da, dd;
    logic [3:0]  dw;
    total = 0; bad = 0;
    model_reset();
    rst_n = 1'b0;
    drive(1, 32'h40, 1, 32'h80, 4'hF, 32'h1234, 1, 32'h5);
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    // fetch alone, single-cycle memory
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    #1 chk("if_alone_stall_c0", 32'(bus.stall_if), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h0050_0093);
    step();
    chk("if_alone_rvalid", 32'(bus.if_rvalid), 1);
    chk("if_alone_rdata", bus.if_rdata, 32'h0050_0093);
    // sw with three wait states
    drive(0, 0, 1, 32'h100, 4'hF, 32'hDEAD_BEEF, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h9999);
    repeat (3) begin
      #1 chk("sw_stall_mem", 32'(bus.stall_mem), 1);
      step();
      chk("sw_mem_we", 32'(bus.mem_we), 32'hF);
    end
    bus.mem_ready = 1;
    step();
    chk("sw_rvalid", 32'(bus.dm_rvalid), 1);
    chk("sw_rdata_kept", bus.dm_rdata, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // both requesting, zero-wait memory: starvation sequence
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h300 + 32'(i), 1, 32'h400 + 32'(i), 0, 0, m_owner != 0, 32'(i));
      #1 chk($sformatf("starve_seq%0d", i), 32'({bus.if_gnt, bus.dm_gnt}), 32'(exp_seq[i]));
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 32'h77);
    step();
    // back-to-back loads
    drive(0, 0, 1, 32'h200, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 32'h204, 0, 0, 1, 32'h11);
    step();
    chk("b2b_req1", 32'(bus.mem_req), 1);
    chk("b2b_rd1", bus.dm_rdata, 32'h11);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h22);
    step();
    chk("b2b_rv2", 32'(bus.dm_rvalid), 1);
    chk("b2b_rd2", bus.dm_rdata, 32'h22);
    // reset during a data wait state
    drive(0, 0, 1, 32'h500, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b0;
    bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0;
    step();
    chk("rst_no_rvalid", 32'(bus.dm_rvalid), 0);
    rst_n = 1'b1;
    drive(1, 32'h600, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_if_gnt", 32'(bus.if_gnt), 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hAB);
    step();
    // ready pulses while idle are ignored
    repeat (3) begin
      drive(0, 0, 0, 0, 0, 0, 1, 32'hCC);
      step();
      chk("idle_ready_req", 32'(bus.mem_req), 0);
    end
    // random traffic honouring the hold-until-grant protocol
    ir = 0; dr = 0; ia = 0; da = 0; dd = 0; dw = 0;
    last_if_gnt = 0; last_dm_gnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ir || last_if_gnt) begin
        ir = $urandom_range(0, 2) != 0;
        ia = $urandom;
      end
      if (!dr || last_dm_gnt) begin
        dr = $urandom_range(0, 2) == 0;
        da = $urandom; dd = $urandom; dw = wes[$urandom_range(0, 3)];
      end
      rst_n = $urandom_range(0, 99) != 0;
      drive(ir, ia, dr, da, dw, dd, $urandom_range(0, 2) != 0, $urandom);
      step();
      if (!rst_n) begin ir = 0; dr = 0; end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
